// File: rtl/pdata_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// pdata_ctrl - host-side sequencer driving a bit-serial pdata PE
// Rev 1.0
// ------------------------------------------------------------------
module pdata_ctrl #(
  parameter int SIZE = 32,
  parameter int CW   = $clog2(4*SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [4*SIZE-1:0]   cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [4*SIZE-1:0]   rsp_data,
  output logic                busy,
  output logic [2:0]          opcode,
  output logic                rx,
  input  logic                tx
);

  localparam int c_W = 4*SIZE;

  localparam logic [2:0] c_OP_OUT_DATA1 = 3'd0;
  localparam logic [2:0] c_OP_OUT_DATA2 = 3'd1;
  localparam logic [2:0] c_OP_OUT_RES   = 3'd2;
  localparam logic [2:0] c_OP_LOAD      = 3'd3;
  localparam logic [2:0] c_OP_LOAD_RES  = 3'd4;
  localparam logic [2:0] c_OP_MUL       = 3'd5;
  localparam logic [2:0] c_OP_MUL_ADD   = 3'd6;
  localparam logic [2:0] c_OP_NO_OP     = 3'd7;

  localparam logic [c_W-1:0] c_ONE     = 1;
  localparam logic [CW:0]    c_N_ONE   = 1;
  localparam logic [CW:0]    c_N_TWO   = 2;
  localparam logic [CW-1:0]  c_CNT_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  function automatic logic [CW:0] shift_len(input logic [2:0] op);
    case (op)
      c_OP_OUT_DATA1, c_OP_OUT_DATA2, c_OP_LOAD: shift_len = (CW+1)'(SIZE);
      c_OP_OUT_RES, c_OP_LOAD_RES:               shift_len = (CW+1)'(c_W);
      c_OP_MUL, c_OP_MUL_ADD:                    shift_len = c_N_ONE;
      default:                                   shift_len = '0;
    endcase
  endfunction

  function automatic logic is_read(input logic [2:0] op);
    is_read = (op == c_OP_OUT_DATA1) || (op == c_OP_OUT_DATA2) || (op == c_OP_OUT_RES);
  endfunction

  state_t         r_state, w_state_nxt;
  logic [2:0]     r_op, w_op_nxt;
  logic [c_W-1:0] r_shreg, w_shreg_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [2:0]     r_opcode, w_opcode_nxt;
  logic           r_rx, w_rx_nxt;
  logic           r_rsp_valid, w_rsp_valid_nxt;
  logic [c_W-1:0] r_rsp_data, w_rsp_data_nxt;

  logic [CW:0]    w_cmd_n, w_op_n;
  logic [CW-1:0]  w_cmd_idx, w_rx_idx;
  logic [c_W-1:0] w_shifted, w_mask;

  assign w_cmd_n   = shift_len(cmd_op);
  assign w_op_n    = shift_len(r_op);
  assign w_cmd_idx = CW'(w_cmd_n - c_N_ONE);
  assign w_rx_idx  = CW'(w_op_n - c_N_TWO);
  assign w_shifted = {r_shreg[c_W-2:0], tx};
  // Shifting by the full width yields zero, so the mask becomes all ones for N = 4*SIZE
  assign w_mask    = (c_ONE << w_op_n) - c_ONE;

  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_shreg_nxt     = r_shreg;
    w_cnt_nxt       = r_cnt;
    w_opcode_nxt    = r_opcode;
    w_rx_nxt        = r_rx;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_shreg_nxt = cmd_data;
          w_op_nxt    = cmd_op;
          if (w_cmd_n != '0) begin
            w_opcode_nxt = cmd_op;
            w_rx_nxt     = cmd_data[w_cmd_idx];
            w_cnt_nxt    = w_cmd_idx;
            w_state_nxt  = S_SHIFT;
          end else begin
            w_rsp_data_nxt  = '0;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = S_RESP;
          end
        end
      end
      S_SHIFT: begin
        w_shreg_nxt = w_shifted;
        if (r_cnt == '0) begin
          w_opcode_nxt    = c_OP_NO_OP;
          w_rx_nxt        = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          // tx floats during write-only ops, so only read ops may reach the response
          w_rsp_data_nxt  = is_read(r_op) ? (w_shifted & w_mask) : '0;
          w_state_nxt     = S_RESP;
        end else begin
          w_rx_nxt  = r_shreg[w_rx_idx];
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= c_OP_NO_OP;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_opcode    <= c_OP_NO_OP;
      r_rx        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_op        <= w_op_nxt;
      r_shreg     <= w_shreg_nxt;
      r_cnt       <= w_cnt_nxt;
      r_opcode    <= w_opcode_nxt;
      r_rx        <= w_rx_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign opcode    = r_opcode;
  assign rx        = r_rx;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: doc/pdata_ctrl.md
Name: pdata_ctrl

Overview:
- Host-side sequencer for the bit-serial pdata processing element.
- Accepts word-level commands over a valid/ready interface and drives the PE's opcode and rx lines for the required number of cycles. Samples the PE's tx line and returns the word read back over a valid/ready response interface.
- Sits between the system bus/host FSM and one pdata PE. The PE is clocked on the same clk.

Parameters:
- SIZE, 32, PE data register width. Accumulator width is 4*SIZE.
- CW, clog2(4*SIZE), bit-counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command (high only in IDLE)
- cmd_op  in  3  PE opcode: 0 OUT_DATA1, 1 OUT_DATA2, 2 OUT_RES, 3 LOAD, 4 LOAD_RES, 5 MUL, 6 MUL_ADD, 7 NO_OP
- cmd_data  in  4*SIZE  word to shift into the PE. Only bits [SIZE-1:0] are used for SIZE-wide ops.
- rsp_valid  out  1  response present
- rsp_ready  in  1  host accepts response
- rsp_data  out  4*SIZE  word read back from the PE, zero-extended
- busy  out  1  state != IDLE
- opcode  out  3  to PE, registered
- rx  out  1  to PE serial input, registered
- tx  in  1  from PE serial output; Z when the PE is not in a read opcode

Behaviour:
- Reset (sync, rst=1 at posedge), overriding everything:
  - state=IDLE, opcode=NO_OP, rx=0, rsp_valid=0, rsp_data=0, shreg=0, cnt=0.
- Shift length N per op:
  - OUT_DATA1, OUT_DATA2, LOAD: N = SIZE.
  - OUT_RES, LOAD_RES: N = 4*SIZE.
  - MUL, MUL_ADD: N = 1.
  - NO_OP: N = 0.
- Read ops are OUT_DATA1, OUT_DATA2 and OUT_RES. All other ops are write-only.
- States:
  - IDLE: cmd_ready=1, opcode=NO_OP. On cmd_valid&&cmd_ready:
    - shreg <= cmd_data, op_q <= cmd_op.
    - If N>0: opcode <= cmd_op, rx <= cmd_data[N-1], cnt <= N-1, go to SHIFT.
    - If N=0: rsp_data <= 0, go to RESP; opcode remains NO_OP.
  - SHIFT: each posedge, shreg <= {shreg[4*SIZE-2:0], tx}, rx <= shreg[N-2] (the next bit, MSB-first).
    - While cnt != 0: cnt <= cnt-1.
    - When cnt==0: opcode <= NO_OP, rx <= 0, go to RESP.
      - Read op: rsp_data <= low N bits of the new shreg, upper bits zeroed.
      - Otherwise: rsp_data <= 0.
    - For MUL/MUL_ADD (N=1), the single SHIFT cycle ends immediately.
  - RESP: rsp_valid=1; rsp_data held stable. On rsp_ready, go to IDLE.
    - cmd_ready is 0 in RESP, so the next command is accepted no earlier than the cycle after the response handshake.
- Timing:
  - opcode equals cmd_op for exactly N consecutive clock edges. The PE performs exactly N shifts (or 1 arithmetic op).
  - Latency from accept edge to rsp_valid is N+1 cycles, or 1 cycle for NO_OP.
- Read semantics:
  - The PE presents its register MSB on tx combinationally, so bit k sampled equals original bit (N-1-k).
  - rsp_data therefore equals the PE register value before the command. The PE register equals cmd_data[N-1:0] after the command (swap).
- tx sampling during write-only ops is don't-care (Z/X). It must never reach rsp_data; it is masked to 0.
- rst asserted mid-SHIFT:
  - Aborts immediately; opcode=NO_OP from the next cycle and no response is issued.
  - PE contents are partially shifted and undefined to the host; the host must reload.
- cmd_valid may drop while not ready; no command is latched. cmd fields are sampled only at the accept edge.

Test Plan:
(Bench: SIZE=8, controller driving a real pdata PE instance; that PE uses an active-low reset, which the bench drives as !rst.)
1. Reset: assert rst for 2 cycles -> opcode=7, rx=0, cmd_ready=1, rsp_valid=0, busy=0.
2. OUT_DATA1 0xA5, then OUT_DATA1 0x3C -> second rsp_data=0xA5; opcode=0 for exactly 8 cycles; rsp_valid on cycle 9 after accept.
3. LOAD 0x03, LOAD 0x05, MUL, OUT_RES cmd_data=0 -> rsp_data=0x0000000F; OUT_DATA2 -> 0x03; OUT_DATA1 -> 0x05.
4. After step 3 reload (LOAD 3, LOAD 5), then MUL, MUL_ADD, MUL_ADD, OUT_RES -> rsp_data=0x0000002D.
5. LOAD_RES 0xDEADBEEF, then OUT_RES 0 -> rsp_data=0xDEADBEEF. Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, cmd_ready=0, opcode=7.
6. Reset after 3 shifts of OUT_DATA2 -> opcode=7 next cycle, no rsp_valid. NO_OP cmd -> rsp_valid 1 cycle after accept, rsp_data=0, opcode never leaves 7.
